// File: rtl/wb_sha_bridge_pkg.sv
// Shared types and constants for the Wishbone-to-SHA-256 register bridge.
// Holds the FSM encoding, address region codes, local register offsets and STATUS bit positions.
package wb_sha_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CORE_REQ = 2'd1,
    CORE_CAP = 2'd2,
    ACK      = 2'd3
  } state_e;

  localparam logic [1:0] RGN_CORE  = 2'b00;
  localparam logic [1:0] RGN_LOCAL = 2'b01;

  localparam logic [9:0] STATUS_OFS  = 10'h000;
  localparam logic [9:0] ACC_CNT_OFS = 10'h004;

  localparam int STATUS_W       = 3;
  localparam int STAT_BAD_SEL   = 0;
  localparam int STAT_CORE_ERR  = 1;
  localparam int STAT_UNMAPPED  = 2;

endpackage

// File: rtl/wb_sha_bridge_if.sv
// Wishbone classic slave-side bundle between the Caravel bus and the SHA bridge.
// The master modport is used by whatever drives the bus cycles.
interface wb_sha_bridge_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_sha_bridge.sv
// Wishbone classic slave in front of the SHA-256 core register port, with a local
// window holding sticky fault flags (W1C), an access counter and a fault interrupt.
module wb_sha_bridge
  import wb_sha_bridge_pkg::*;
#(
  parameter logic [31:0] BASE    = 32'h3000_0000,
  parameter logic [31:0] MASK    = 32'hFFFF_F000,
  parameter int unsigned CORE_AW = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  wb_sha_bridge_if.slave     wbs,
  output logic               core_cs,
  output logic               core_we,
  output logic [CORE_AW-1:0] core_address,
  output logic [31:0]        core_write_data,
  input  logic [31:0]        core_read_data,
  input  logic               core_error,
  output logic               err_irq
);

  function automatic logic is_hit(input logic [31:0] adr);
    return (adr & MASK) == BASE;
  endfunction

  state_e                state_q, state_d;
  logic                  abort_q, abort_d;
  logic                  core_cs_q, core_cs_d;
  logic                  ack_q, ack_d;
  logic                  core_we_q, core_we_d;
  logic [CORE_AW-1:0]    core_addr_q, core_addr_d;
  logic [31:0]           core_wdata_q, core_wdata_d;
  logic [31:0]           ack_dat_q, ack_dat_d;
  logic [STATUS_W-1:0]   status_q, status_d;
  logic [15:0]           acc_cnt_q, acc_cnt_d;

  logic                  req;
  logic                  core_go;
  logic [1:0]            rgn;
  logic [9:0]            ofs;
  logic [31:0]           local_rd;

  assign rgn     = wbs.wbs_adr_i[11:10];
  assign ofs     = wbs.wbs_adr_i[9:0];
  assign req     = wbs.wbs_cyc_i & wbs.wbs_stb_i & is_hit(wbs.wbs_adr_i);
  assign core_go = (rgn == RGN_CORE) && (!wbs.wbs_we_i || (wbs.wbs_sel_i == 4'hF));

  always_comb begin
    local_rd = '0;
    if (ofs == STATUS_OFS)       local_rd[STATUS_W-1:0] = status_q;
    else if (ofs == ACC_CNT_OFS) local_rd[15:0]         = acc_cnt_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      abort_q <= abort_d;
    end
  end

  // A dropped cyc during the core strobe still lets the core access finish; only the ack is skipped.
  always_comb begin
    state_d = state_q;
    abort_d = (state_q == CORE_REQ) && !wbs.wbs_cyc_i;
    unique case (state_q)
      IDLE:     if (req) state_d = core_go ? CORE_REQ : ACK;
      CORE_REQ: state_d = CORE_CAP;
      CORE_CAP: state_d = (abort_q || !wbs.wbs_cyc_i) ? IDLE : ACK;
      ACK:      state_d = IDLE;
    endcase
  end

  always_comb begin
    core_we_d    = core_we_q;
    core_addr_d  = core_addr_q;
    core_wdata_d = core_wdata_q;
    ack_dat_d    = ack_dat_q;
    status_d     = status_q;
    acc_cnt_d    = acc_cnt_q;
    if (state_q == IDLE && req) begin
      if (core_go) begin
        core_we_d    = wbs.wbs_we_i;
        core_addr_d  = wbs.wbs_adr_i[CORE_AW+1:2];
        core_wdata_d = wbs.wbs_dat_i;
      end else if (rgn == RGN_CORE) begin
        status_d[STAT_BAD_SEL] = 1'b1;
        ack_dat_d              = '0;
      end else if (rgn == RGN_LOCAL) begin
        ack_dat_d = local_rd;
        if (wbs.wbs_we_i && ofs == STATUS_OFS)
          status_d = status_q & ~wbs.wbs_dat_i[STATUS_W-1:0];
      end else begin
        status_d[STAT_UNMAPPED] = 1'b1;
        ack_dat_d               = '0;
      end
    end else if (state_q == CORE_CAP) begin
      ack_dat_d = core_read_data;
      acc_cnt_d = acc_cnt_q + 16'd1;
      if (core_error) status_d[STAT_CORE_ERR] = 1'b1;
    end
    core_cs_d = (state_d == CORE_REQ);
    ack_d     = (state_d == ACK);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_cs_q    <= 1'b0;
      ack_q        <= 1'b0;
      core_we_q    <= 1'b0;
      core_addr_q  <= '0;
      core_wdata_q <= '0;
      ack_dat_q    <= '0;
      status_q     <= '0;
      acc_cnt_q    <= '0;
    end else begin
      core_cs_q    <= core_cs_d;
      ack_q        <= ack_d;
      core_we_q    <= core_we_d;
      core_addr_q  <= core_addr_d;
      core_wdata_q <= core_wdata_d;
      ack_dat_q    <= ack_dat_d;
      status_q     <= status_d;
      acc_cnt_q    <= acc_cnt_d;
    end
  end

  assign core_cs         = core_cs_q;
  assign core_we         = core_we_q;
  assign core_address    = core_addr_q;
  assign core_write_data = core_wdata_q;
  assign wbs.wbs_ack_o   = ack_q;
  assign wbs.wbs_dat_o   = ack_q ? ack_dat_q : 32'd0;
  assign err_irq         = |status_q;

endmodule

// File: doc/wb_sha_bridge.md
# wb_sha_bridge

Wishbone classic slave that sits directly upstream of the SHA-256 core inside the user project wrapper. It converts Caravel bus cycles (`wbs_*`) into the core's single-cycle `cs`/`we`/`address`/`write_data` register port, captures `read_data`/`error` and returns a properly timed `wbs_ack_o`. It also provides a small local register window: sticky fault flags, an access counter and a fault interrupt.

## Interface
Parameters:
- `BASE` = 32'h3000_0000: bus base address of the block.
- `MASK` = 32'hFFFF_F000: compare mask. The block is hit when `(wbs_adr_i & MASK) == BASE`.
- `CORE_AW` = 8: core word-address width.

Ports:
- `clk`  in  1  single clock, tied to `wb_clk_i`.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1 each  Wishbone classic controls.
- `wbs_sel_i`  in  4  byte selects.
- `wbs_adr_i`  in  32  byte address.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  one-cycle acknowledge.
- `wbs_dat_o`  out  32  read data; valid only while `wbs_ack_o`=1, 0 otherwise.
- `core_cs`, `core_we`  out  1 each  core strobe and write enable. Both are registered.
- `core_address`  out  `CORE_AW`  core word address, `wbs_adr_i[9:2]`.
- `core_write_data`  out  32  registered copy of `wbs_dat_i`.
- `core_read_data`  in  32  core read data, registered in the core and valid one cycle after `core_cs`.
- `core_error`  in  1  core error, sampled together with `core_read_data`.
- `err_irq`  out  1  level interrupt: OR of the STATUS flags.

## Operation
Address regions, decoded by `wbs_adr_i[11:10]` on a hit:
- 00: core window.
- 01: local registers.
  - Offset 0x0 STATUS. bit0 BAD_SEL, bit1 CORE_ERR, bit2 UNMAPPED. All are sticky. Writing 1 clears a bit.
  - Offset 0x4 ACC_CNT[15:0], read-only, wraps 0xFFFF→0.
  - Other offsets read 0 and ignore writes.
- 10/11: unmapped. The access is acked, reads return 0, and UNMAPPED is set.
- A miss (address outside `BASE`/`MASK`) gives no ack and no side effects.

FSM states: IDLE, CORE_REQ, CORE_CAP, ACK.
- **IDLE**, on `cyc & stb & hit`:
  - Core window, with a read or `sel`==4'hF: go to CORE_REQ and latch `core_we`, `core_address` and `core_write_data`.
  - Core write with `sel`≠4'hF: no core access. Set BAD_SEL and go to ACK.
  - Local or unmapped access: perform the register action and go to ACK.
- **CORE_REQ**: `core_cs`=1 for exactly this one cycle. Then go to CORE_CAP.
- **CORE_CAP**: register `core_read_data` into the ack data register. If `core_error`=1, set CORE_ERR. Increment ACC_CNT. Then go to ACK.
- **ACK**: `wbs_ack_o`=1 for one cycle. Then go to IDLE. The master drops `stb` on the same edge, so IDLE never re-accepts the finished cycle.
- **Abort**: if `cyc` falls while the FSM is in CORE_REQ or CORE_CAP, the core access still completes. Capture and counting still happen. ACK is skipped and the FSM returns to IDLE.
- A new request is never accepted outside IDLE.
- STATUS set and clear cannot coincide, because a single master means no core access is in flight during a local write.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE.
  - STATUS = 0, ACC_CNT = 0.
  - Latched core address, data and `we` = 0.
- Core access latency: `stb` sampled at edge E0, `core_cs` high during E0→E1, data captured at E2, `wbs_ack_o` high during E2→E3. That is 3 cycles from request to the ack edge.
- Local, unmapped and BAD_SEL accesses: ack during E0→E1, 1 cycle.
- `err_irq` is combinational from the STATUS register. It rises the cycle after the flag-setting edge.
- Reset asserted mid-operation: `core_cs` and `wbs_ack_o` drop immediately, and no partial state survives.

## Structure
- Package `wb_sha_bridge_pkg` holds:
  - the state enum;
  - region codes;
  - register offsets (`STATUS_OFS`=0x0, `ACC_CNT_OFS`=0x4);
  - STATUS bit indices.
- Single module with no sub-module. The decode is a local function.

## Test plan
- **Reset:** assert `reset_n`=0 mid-transfer → all outputs 0, STATUS=0, ACC_CNT=0.
- **Core write:** write 0x3000_0010, data 0x6162_6364, sel F → one-cycle `core_cs` with `core_we`=1, `core_address`=0x04, `core_write_data`=0x6162_6364; ack 3 cycles after request; ACC_CNT=1.
- **Core read:** read 0x3000_0020 with the core returning 0xDEAD_BEEF → `core_address`=0x08, `core_we`=0; `wbs_dat_o`=0xDEAD_BEEF exactly during ack; 0 otherwise.
- **Partial write:** write with sel 4'h3 to 0x3000_0000 → no `core_cs`; ack after 1 cycle; STATUS reads 0x1; `err_irq`=1. Writing 0x1 to 0x3000_0400 → STATUS 0, `err_irq` 0.
- **Core error and unmapped:** `core_error`=1 on a read → STATUS bit1 set. Access to 0x3000_0800 → ack, read 0, STATUS bit2 set. Access to 0x2000_0000 → no ack, no `core_cs`.
- **Abort and wrap:** drop `cyc` during CORE_REQ → no ack, but ACC_CNT increments; the next read is served normally. Preload 0xFFFF accesses → the next access wraps ACC_CNT to 0.
